// File: rtl/host_link_ctrl_pkg.sv
// Shared definitions for the host link controller: state encoding and default widths.
package host_link_ctrl_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned N_CORES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

endpackage

// File: rtl/host_link_unloader.sv
// Result window reader: issues one memory read per cycle and tracks the
// matching one-cycle-late valid and last-word flags.
module host_link_unloader
  import host_link_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              valid,
  output logic              last
);

  logic              issuing;
  logic [ADDR_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      remaining <= '0;
      issuing   <= 1'b0;
      valid     <= 1'b0;
      last      <= 1'b0;
    end else begin
      // Data for the address issued this cycle is on mem_rdata next cycle.
      valid <= issuing;
      last  <= issuing && (remaining == ADDR_W'(1));
      if (start) begin
        rd_addr   <= base;
        remaining <= (len == '0) ? ADDR_W'(1) : len;
        issuing   <= 1'b1;
      end else if (issuing) begin
        rd_addr   <= rd_addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
        if (remaining == ADDR_W'(1)) issuing <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/host_link_ctrl.sv
// Host link controller: loads host words into shared memory, launches the
// selected cores, waits for all of them and streams a result window back.
module host_link_ctrl
  import host_link_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned N_CORES = N_CORES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  com_data_in,
  input  logic               data_write_start,
  input  logic               data_write_done,
  input  logic [N_CORES-1:0] n_cores,
  input  logic [ADDR_W-1:0]  out_base,
  input  logic [ADDR_W-1:0]  out_len,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [N_CORES-1:0] core_start,
  input  logic [N_CORES-1:0] core_done,
  output logic [DATA_W-1:0]  com_data_out,
  output logic               output_write_start,
  output logic               output_write_done,
  output logic [1:0]         state,
  output logic               overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t             state_q;
  logic [CNT_W-1:0]   wr_cnt;
  logic               full;
  logic [N_CORES-1:0] mask;
  logic [N_CORES-1:0] done_seen;
  logic [N_CORES-1:0] done_next;
  logic               all_done;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  len_q;
  logic               unl_start;
  logic [ADDR_W-1:0]  unl_base;
  logic [ADDR_W-1:0]  unl_len;
  logic [ADDR_W-1:0]  rd_addr;
  logic               unl_valid;
  logic               unl_last;
  logic [DATA_W-1:0]  data_hold;

  assign full      = wr_cnt[ADDR_W];
  assign done_next = done_seen | (core_done & mask);
  assign all_done  = (done_next & mask) == mask;

  // The unloader is armed on the edge that enters UNLOAD, from either LOAD or RUN.
  assign unl_start = ((state_q == ST_LOAD) && data_write_done && (n_cores == '0)) ||
                     ((state_q == ST_RUN) && all_done);
  assign unl_base  = (state_q == ST_LOAD) ? out_base : base_q;
  assign unl_len   = (state_q == ST_LOAD) ? out_len : len_q;

  assign mem_we    = (state_q == ST_LOAD) && data_write_start && !data_write_done && !full;
  assign mem_addr  = (state_q == ST_LOAD) ? wr_cnt[ADDR_W-1:0] : rd_addr;
  assign mem_wdata = (state_q == ST_LOAD) ? com_data_in : '0;

  assign com_data_out       = unl_valid ? mem_rdata : data_hold;
  assign output_write_start = unl_valid;
  assign output_write_done  = unl_last;
  assign state              = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_cnt     <= '0;
      mask       <= '0;
      done_seen  <= '0;
      base_q     <= '0;
      len_q      <= '0;
      core_start <= '0;
      overflow   <= 1'b0;
      data_hold  <= '0;
    end else begin
      core_start <= '0;
      if (unl_valid) data_hold <= mem_rdata;
      case (state_q)
        ST_IDLE: begin
          if (data_write_start) begin
            state_q  <= ST_LOAD;
            wr_cnt   <= '0;
            overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (data_write_done) begin
            mask      <= n_cores;
            base_q    <= out_base;
            len_q     <= out_len;
            done_seen <= '0;
            if (n_cores != '0) begin
              state_q    <= ST_RUN;
              core_start <= n_cores;
            end else begin
              state_q <= ST_UNLOAD;
            end
          end else if (data_write_start) begin
            if (full) overflow <= 1'b1;
            else      wr_cnt   <= wr_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          done_seen <= done_next;
          if (all_done) state_q <= ST_UNLOAD;
        end
        ST_UNLOAD: begin
          if (unl_last) begin
            state_q   <= ST_IDLE;
            done_seen <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  host_link_unloader #(.ADDR_W(ADDR_W)) u_unloader (
    .clk     (clk),
    .rst     (rst),
    .start   (unl_start),
    .base    (unl_base),
    .len     (unl_len),
    .rd_addr (rd_addr),
    .valid   (unl_valid),
    .last    (unl_last)
  );

endmodule

// File: tb/tb_host_link_ctrl.sv
// Scoreboard bench for host_link_ctrl: a default-size instance and a 4-word
// instance share stimulus; sel picks which one is observed.
module tb_host_link_ctrl;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 8;
  localparam int unsigned AWS = 2;
  localparam int unsigned NC  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] com_data_in;
  logic          data_write_start, data_write_done;
  logic [NC-1:0] n_cores, core_done;
  logic [AW-1:0] out_base, out_len;
  logic          sel;

  logic           we_b, ows_b, owd_b, ovf_b;
  logic [AW-1:0]  addr_b;
  logic [DW-1:0]  wdata_b, rdata_b, dout_b;
  logic [NC-1:0]  cs_b;
  logic [1:0]     st_b;
  logic           we_s, ows_s, owd_s, ovf_s;
  logic [AWS-1:0] addr_s;
  logic [DW-1:0]  wdata_s, rdata_s, dout_s;
  logic [NC-1:0]  cs_s;
  logic [1:0]     st_s;

  logic [DW-1:0] mem_b [0:255];
  logic [DW-1:0] mem_s [0:3];
  logic [DW-1:0] exp_b [0:255];
  logic [DW-1:0] exp_s [0:3];
  logic [DW-1:0] sb [$];

  int n_chk = 0;
  int n_pass = 0;

  host_link_ctrl u_big (
    .clk(clk), .rst(rst), .com_data_in(com_data_in),
    .data_write_start(data_write_start), .data_write_done(data_write_done),
    .n_cores(n_cores), .out_base(out_base), .out_len(out_len),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .core_start(cs_b), .core_done(core_done), .com_data_out(dout_b),
    .output_write_start(ows_b), .output_write_done(owd_b),
    .state(st_b), .overflow(ovf_b)
  );

  host_link_ctrl #(.ADDR_W(AWS)) u_small (
    .clk(clk), .rst(rst), .com_data_in(com_data_in),
    .data_write_start(data_write_start), .data_write_done(data_write_done),
    .n_cores(n_cores), .out_base(out_base[AWS-1:0]), .out_len(out_len[AWS-1:0]),
    .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wdata_s), .mem_rdata(rdata_s),
    .core_start(cs_s), .core_done(core_done), .com_data_out(dout_s),
    .output_write_start(ows_s), .output_write_done(owd_s),
    .state(st_s), .overflow(ovf_s)
  );

  // Synchronous-read memories, one per instance.
  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= wdata_b;
    rdata_b <= mem_b[addr_b];
    if (we_s) mem_s[addr_s] <= wdata_s;
    rdata_s <= mem_s[addr_s];
  end

  logic [1:0]    o_st;
  logic [NC-1:0] o_cs;
  logic          o_ows, o_owd, o_ovf;
  logic [DW-1:0] o_dout;
  assign o_st   = sel ? st_s   : st_b;
  assign o_cs   = sel ? cs_s   : cs_b;
  assign o_ows  = sel ? ows_s  : ows_b;
  assign o_owd  = sel ? owd_s  : owd_b;
  assign o_ovf  = sel ? ovf_s  : ovf_b;
  assign o_dout = sel ? dout_s : dout_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, o_st, 0);
    check({tag, "_cs"}, o_cs, 0);
    check({tag, "_ows"}, o_ows, 0);
    check({tag, "_owd"}, o_owd, 0);
    check({tag, "_dout"}, o_dout, 0);
    check({tag, "_ovf"}, o_ovf, 0);
  endtask

  // One full session; abort_at >= 0 applies a one-cycle reset at that RUN cycle.
  task automatic session(input int nw, input int w0, input int ws,
                         input logic [NC-1:0] mask, input int base, input int len,
                         input int d0, input int d1, input int d2, input int d3,
                         input int abort_at);
    int d [4];
    int depth, need, cyc;
    bit fin, exp_done;
    logic [DW-1:0] w, e, last_word;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    depth = sel ? 4 : 256;
    last_word = '0;

    data_write_start = 1'b1;
    tick();
    check("enter_load", o_st, 1);
    for (int i = 0; i < nw; i++) begin
      w = DW'(w0 + i * ws);
      com_data_in = w;
      if (i < 256) exp_b[i] = w;
      if (i < 4) exp_s[i] = w;
      tick();
    end
    data_write_done = 1'b1;
    com_data_in = 16'hdead;
    n_cores  = mask;
    out_base = AW'(base);
    out_len  = AW'(len);
    tick();
    data_write_done  = 1'b0;
    data_write_start = 1'b0;
    // Later changes must not affect the running session.
    n_cores  = 4'hf;
    out_base = 8'haa;
    out_len  = 8'h07;
    check("overflow", o_ovf, (nw > depth));

    need = (len == 0) ? 1 : len;
    for (int i = 0; i < need; i++)
      sb.push_back(sel ? exp_s[(base + i) % 4] : exp_b[(base + i) % 256]);

    if (mask != '0) begin
      check("start_pulse", o_cs, mask);
      check("run_state", o_st, 2);
      fin = 1'b0;
      for (cyc = 0; cyc < 40 && !fin; cyc++) begin
        core_done = '0;
        for (int i = 0; i < 4; i++) if (d[i] == cyc) core_done[i] = 1'b1;
        tick();
        if (cyc == 0) check("start_cleared", o_cs, 0);
        if (cyc == abort_at) begin
          rst = 1'b1;
          core_done = '0;
          tick();
          rst = 1'b0;
          check_reset_outputs("abort");
          tick();
          check("abort_stay_idle", o_st, 0);
          check("abort_no_repulse", o_cs, 0);
          sb.delete();
          return;
        end
        exp_done = 1'b1;
        for (int i = 0; i < 4; i++)
          if (mask[i] && !(d[i] >= 0 && d[i] <= cyc)) exp_done = 1'b0;
        if (exp_done) begin
          check("run_exit", o_st, 3);
          fin = 1'b1;
        end else begin
          check("run_wait", o_st, 2);
        end
      end
      core_done = '0;
    end else begin
      check("skip_run", o_st, 3);
      check("no_start", o_cs, 0);
    end

    check("unload_first_idle", o_ows, 0);
    fin = 1'b0;
    for (cyc = 0; cyc < need + 3 && !fin; cyc++) begin
      tick();
      check("valid", o_ows, 1);
      if (o_ows) begin
        if (sb.size() == 0) begin
          check("extra_word", o_ows, 0);
          fin = 1'b1;
        end else begin
          e = sb.pop_front();
          check("data", o_dout, e);
          check("last_flag", o_owd, (sb.size() == 0));
          last_word = e;
          if (o_owd) fin = 1'b1;
        end
      end
    end
    check("unload_finished", fin, 1);
    tick();
    check("back_idle", o_st, 0);
    check("ows_low", o_ows, 0);
    check("dout_hold", o_dout, last_word);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    com_data_in = '0;
    data_write_start = 1'b0;
    data_write_done = 1'b0;
    n_cores = '0;
    core_done = '0;
    out_base = '0;
    out_len = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    sel = 1'b0;
    session(5, 10, 10, 4'b0111, 0, 5, 1, 2, 3, -1, -1);
    session(5, 100, 1, 4'b0101, 0, 4, 3, -1, 9, 4, -1);
    session(3, 7, 3, 4'b0000, 0, 3, -1, -1, -1, -1, -1);
    sel = 1'b1;
    session(6, 1, 1, 4'b0001, 2, 3, 1, -1, -1, -1, -1);
    sel = 1'b0;
    session(4, 500, 5, 4'b1000, 1, 0, -1, -1, -1, 2, -1);
    session(5, 11, 11, 4'b0111, 0, 5, -1, -1, -1, -1, 3);
    session(5, 10, 10, 4'b0111, 0, 5, 1, 2, 3, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
